mem_line_ctrl: RTL



---
 rtl/mem_line_ctrl_pkg.sv | 25 ++
 rtl/mem_line_ctrl_if.sv | 39 +++
 rtl/mem_line_ctrl_rd_lat_pipe.sv | 38 +++
 rtl/mem_line_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_line_ctrl_pkg.sv
// Shared definitions for the line-granular memory controller and the cache.
// Holds the FSM state type, default geometry and word-slice helpers.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam int DEF_WORD_WIDTH      = 32;
    localparam int DEF_WORDS_PER_LINE  = 4;
    localparam int DEF_RAM_ADDR_WIDTH  = 10;
    localparam int DEF_LINE_WIDTH      = DEF_WORD_WIDTH * DEF_WORDS_PER_LINE;
    localparam int DEF_WORD_IDX_WIDTH  = $clog2(DEF_WORDS_PER_LINE);
    localparam int DEF_LINE_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH - DEF_WORD_IDX_WIDTH;

    // Bit offset of word idx inside a packed line.
    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned word_width);
        return idx * word_width;
    endfunction

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Request/response and RAM-port bundle of mem_line_ctrl.
// slave = controller side, master = requester plus RAM side.
interface mem_line_ctrl_if #(
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int RAM_ADDR_WIDTH = 10
);
    localparam int LINE_WIDTH      = WORD_WIDTH * WORDS_PER_LINE;
    localparam int LINE_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(WORDS_PER_LINE);

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [LINE_ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0]      req_wdata;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [LINE_WIDTH-1:0]      resp_rdata;
    logic                       ram_en;
    logic                       ram_we;
    logic                       ram_regce;
    logic                       ram_rst;
    logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
    logic [WORD_WIDTH-1:0]      ram_din;
    logic [WORD_WIDTH-1:0]      ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, ram_dout,
        output req_ready, resp_valid, resp_rdata,
        output ram_en, ram_we, ram_regce, ram_rst, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, ram_dout,
        input  req_ready, resp_valid, resp_rdata,
        input  ram_en, ram_we, ram_regce, ram_rst, ram_addr, ram_din
    );

endinterface

// File: rtl/mem_line_ctrl_rd_lat_pipe.sv
// Valid+index shift register that tags each issued RAM read and releases
// the tag exactly when the RAM data for that read is on ram_dout.
module rd_lat_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [DEPTH-1:0] r_vld;
    logic [IDX_W-1:0] r_idx [DEPTH];

    // Shift tags one stage per clock; reset drops all in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_idx[0] <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/mem_line_ctrl.sv
// Line-granular controller: issues one RAM word per cycle for a cache line,
// realigns read data over the RAM latency and returns one line response.
module mem_line_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter int READ_LATENCY   = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_line_ctrl_if.slave bus
);

    localparam int LINE_WIDTH      = WORD_WIDTH * WORDS_PER_LINE;
    localparam int WIDX_W          = $clog2(WORDS_PER_LINE);
    localparam int LINE_ADDR_WIDTH = RAM_ADDR_WIDTH - WIDX_W;
    localparam logic [WIDX_W-1:0] K_ONE  = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] K_LAST = WIDX_W'(WORDS_PER_LINE - 1);

    state_e                     r_state;
    logic [LINE_ADDR_WIDTH-1:0] r_line_addr;
    logic [LINE_WIDTH-1:0]      r_wdata;
    logic [WIDX_W-1:0]          r_k;
    logic                       r_req_ready;
    logic                       r_resp_valid;
    logic [LINE_WIDTH-1:0]      r_resp_rdata;
    logic                       r_ram_en;
    logic                       r_ram_we;
    logic                       r_ram_regce;
    logic [RAM_ADDR_WIDTH-1:0]  r_ram_addr;
    logic [WORD_WIDTH-1:0]      r_ram_din;

    logic              w_cap_vld;
    logic [WIDX_W-1:0] w_cap_idx;
    logic [WIDX_W-1:0] w_k_nxt;

    assign w_k_nxt = r_k + K_ONE;

    // The tag is taken from the registered RAM controls, i.e. at the issue edge.
    rd_lat_pipe #(
        .DEPTH (READ_LATENCY),
        .IDX_W (WIDX_W)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_ram_en & ~r_ram_we),
        .i_idx   (r_ram_addr[WIDX_W-1:0]),
        .o_valid (w_cap_vld),
        .o_idx   (w_cap_idx)
    );

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_line_addr  <= '0;
            r_wdata      <= '0;
            r_k          <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_regce  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_line_addr  <= bus.req_addr;
                        r_wdata      <= bus.req_wdata;
                        r_k          <= '0;
                        r_req_ready  <= 1'b0;
                        r_resp_rdata <= '0;
                        r_ram_en     <= 1'b1;
                        r_ram_we     <= bus.req_we;
                        r_ram_regce  <= ~bus.req_we;
                        r_ram_addr   <= {bus.req_addr, {WIDX_W{1'b0}}};
                        r_ram_din    <= bus.req_we ? bus.req_wdata[WORD_WIDTH-1:0] : '0;
                        r_state      <= bus.req_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (r_k == K_LAST) begin
                        r_ram_en     <= 1'b0;
                        r_ram_we     <= 1'b0;
                        r_ram_addr   <= '0;
                        r_ram_din    <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_k        <= w_k_nxt;
                        r_ram_addr <= {r_line_addr, w_k_nxt};
                        r_ram_din  <= r_wdata[word_lsb(w_k_nxt, WORD_WIDTH) +: WORD_WIDTH];
                    end
                end
                ST_READ: begin
                    if (w_cap_vld) begin
                        r_resp_rdata[word_lsb(w_cap_idx, WORD_WIDTH) +: WORD_WIDTH] <= bus.ram_dout;
                    end
                    if (r_k == K_LAST) begin
                        r_ram_en   <= 1'b0;
                        r_ram_addr <= '0;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_k        <= w_k_nxt;
                        r_ram_addr <= {r_line_addr, w_k_nxt};
                    end
                end
                ST_DRAIN: begin
                    if (w_cap_vld) begin
                        r_resp_rdata[word_lsb(w_cap_idx, WORD_WIDTH) +: WORD_WIDTH] <= bus.ram_dout;
                    end
                    // Reads return in issue order, so the last index closes the line.
                    if (w_cap_vld && (w_cap_idx == K_LAST)) begin
                        r_ram_regce  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_ram_en     <= 1'b0;
                    r_ram_we     <= 1'b0;
                    r_ram_regce  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.ram_en     = r_ram_en;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_regce  = r_ram_regce;
    assign bus.ram_rst    = 1'b0;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_din    = r_ram_din;

endmodule
